ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Owns a single-port AW x DW synchronous RAM; shares it between two requesters.
- Port A: SPI command engine (RAM read/write commands). Port B: secondary on-chip agent, e.g. GPIO sampler or capture logic.
- Round-robin arbitration with optional locked bursts; per-access req/ack handshake; fixed, deterministic latency.

Parameters:
- AW, 8, RAM address width (depth 2**AW).
- DW, 8, RAM data width.
- MAX_BURST, 16, max consecutive grants to a locking requester while the other waits (range 1..255).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  port A access request; held until a_ack.
- a_we  input  1  port A: 1 = write, 0 = read; stable while a_req.
- a_lock  input  1  port A requests grant retention for the next access.
- a_addr  input  AW  port A address.
- a_wdata  input  DW  port A write data.
- a_rdata  output  DW  port A read data; valid in the a_ack cycle.
- a_ack  output  1  one-cycle completion pulse for port A.
- b_req, b_we, b_lock, b_addr, b_wdata, b_rdata, b_ack  same widths and meanings for port B.
- grant  output  2  one-hot owner of the current access: 01 = A, 10 = B, 00 = idle.
- busy  output  1  high in ACCESS and ACK states.

Behaviour:
- Reset (async assert, sync release): state IDLE; grant = 00; busy = 0; a_ack = b_ack = 0; a_rdata = b_rdata = 0; last_winner = B, so A wins the first tie; burst_cnt = 0. RAM contents are not reset.
- Reset mid-access aborts the access. An in-flight write may or may not land; no ack is produced.
- State machine: IDLE -> ACCESS -> ACK -> IDLE.
- IDLE:
  - If any req is high, select a winner, register its we/addr/wdata into the RAM port, set grant, go to ACCESS.
  - If no req, stay in IDLE with grant = 00.
- Winner selection:
  - Only one req high: that port wins.
  - Both high: the port that did not win last wins, unless the lock rule applies.
- Lock rule:
  - Applies when last_winner's lock was high at its previous grant and burst_cnt < MAX_BURST. Then last_winner wins again.
  - burst_cnt increments on each consecutive same-port grant while the other port's req is high.
  - burst_cnt clears on a grant to the other port, or when the other req is low.
  - At MAX_BURST with the other port waiting, the other port is forced to win.
- ACCESS: RAM performs the synchronous read or write, one cycle. The write commits at the end of this cycle.
- ACK:
  - Winner's ack = 1 for exactly one cycle. Its rdata is updated with the RAM output on reads; it holds the previous value on writes.
  - The loser's ack and rdata are unchanged.
  - grant keeps its value through ACK and returns to 00 in IDLE.
- Latency: request sampled in IDLE at cycle N -> ack at cycle N+2. A continuously requesting port gets one access per 3 cycles. Two contending ports alternate A,B,A,B.
- Requester rule: drop req, or present the next request, at the clock edge that ends its ack cycle. A req still high in the following IDLE is treated as a new request.
- A read after a write to the same address, issued by either port, returns the new data.
- Address wrap: none internal; addresses are taken as given, modulo 2**AW.
- Changes to req, we, addr or wdata outside IDLE sampling are ignored until the next IDLE.

Test Plan:
- Reset, then A writes addr 0x10 = 0x5A -> a_ack pulses exactly 2 cycles after sampling, grant = 01 during ACCESS and ACK; A then reads 0x10 -> a_rdata = 0x5A on a_ack.
- A and B request in the same cycle straight after reset (A read 0x00, B write 0x01 = 0x33) -> A served first, B second; grant sequence 01, 10; B later reads 0x01 = 0x33.
- A and B both request continuously for 8 accesses, no lock -> strict alternation A,B,A,B...; each port's ack every 6 cycles.
- MAX_BURST = 4, A requests continuously with a_lock = 1, B requests continuously -> pattern A,A,A,A,A,B,A... (4 retained grants after the first, then forced switch); b_ack never starves.
- Assert rst_n = 0 during ACCESS of a B write -> b_ack never pulses; grant = 00 and busy = 0 immediately; after release A's request is granted first.
- B write then A read of the same address 0xFF in back-to-back arbitration -> A returns B's data; b_rdata holds its previous value across B's write ack.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: single-port synchronous RAM shared by two requesters.
// Round-robin arbitration with optional locked bursts; fixed IDLE->ACCESS->ACK access cycle.
module ram_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          a_req,
    input  logic          a_we,
    input  logic          a_lock,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    output logic          a_ack,

    input  logic          b_req,
    input  logic          b_we,
    input  logic          b_lock,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic [DW-1:0] b_rdata,
    output logic          b_ack,

    output logic [1:0]    grant,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ACK
    } state_t;

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    state_t        r_state;
    logic [1:0]    r_grant;
    logic          r_busy;
    logic          r_a_ack;
    logic          r_b_ack;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_last_b;
    logic          r_last_lock;
    logic [7:0]    r_burst_cnt;
    logic [DW-1:0] r_a_hold;
    logic [DW-1:0] r_b_hold;
    logic [DW-1:0] r_ram_q;
    logic [DW-1:0] r_mem [2**AW];

    logic          w_any_req;
    logic          w_lock_hold;
    logic          w_pick_b;
    logic          w_other_req;
    logic          w_same;
    logic          w_ram_en;
    logic [7:0]    w_burst_nxt;

    // Winner selection: a locked previous winner keeps the RAM until its burst
    // budget is spent; otherwise contention alternates.
    always_comb begin
        w_any_req   = a_req | b_req;
        w_lock_hold = r_last_lock && (r_burst_cnt < BURST_MAX);
        if (a_req && b_req) begin
            w_pick_b = r_last_b ? w_lock_hold : !w_lock_hold;
        end else begin
            w_pick_b = b_req;
        end
        w_other_req = w_pick_b ? a_req : b_req;
        w_same      = (w_pick_b == r_last_b);
        w_burst_nxt = (w_same && w_other_req) ? r_burst_cnt + 8'd1 : '0;
        w_ram_en    = (r_state == S_ACCESS);
    end

    // RAM array kept out of the reset domain so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_ram_en) begin
            if (r_we) begin
                r_mem[r_addr] <= r_wdata;
            end else begin
                r_ram_q <= r_mem[r_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_last_b    <= 1'b1;
            r_last_lock <= 1'b0;
            r_burst_cnt <= '0;
            r_a_hold    <= '0;
            r_b_hold    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= S_ACCESS;
                        r_busy      <= 1'b1;
                        r_grant     <= w_pick_b ? 2'b10 : 2'b01;
                        r_we        <= w_pick_b ? b_we    : a_we;
                        r_addr      <= w_pick_b ? b_addr  : a_addr;
                        r_wdata     <= w_pick_b ? b_wdata : a_wdata;
                        r_last_b    <= w_pick_b;
                        r_last_lock <= w_pick_b ? b_lock  : a_lock;
                        r_burst_cnt <= w_burst_nxt;
                    end else begin
                        r_grant <= '0;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_ACK;
                    r_a_ack <= r_grant[0];
                    r_b_ack <= r_grant[1];
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_grant <= '0;
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                    if (!r_we) begin
                        if (r_a_ack) r_a_hold <= r_ram_q;
                        if (r_b_ack) r_b_hold <= r_ram_q;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // During a read ack the RAM output is forwarded; the hold register captures it as ACK ends.
    assign a_rdata = (r_a_ack && !r_we) ? r_ram_q : r_a_hold;
    assign b_rdata = (r_b_ack && !r_we) ? r_ram_q : r_b_hold;
    assign a_ack   = r_a_ack;
    assign b_ack   = r_b_ack;
    assign grant   = r_grant;
    assign busy    = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed stimulus against a cycle-level reference
// model; expected acks are queued at arbitration time and checked by a monitor.
module tb_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic [DW-1:0] a_rdata;
    logic          a_ack;
    logic          b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic [DW-1:0] b_rdata;
    logic          b_ack;
    logic [1:0]    grant;
    logic          busy;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
        .grant(grant), .busy(busy)
    );

    typedef struct {
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } req_t;

    typedef struct {
        int            port;
        int            cyc;
        logic [DW-1:0] rd_a;
        logic [DW-1:0] rd_b;
    } exp_t;

    req_t qa[$];
    req_t qb[$];
    exp_t sb[$];
    int   order[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // requester state
    logic act_a = 1'b0, act_b = 1'b0;
    int   done_a = -10, done_b = -10;
    int   idle_a = 0, idle_b = 0;

    // reference model state
    logic [DW-1:0] m_mem [2**AW];
    logic [DW-1:0] m_rd  [2];
    int            m_last;
    logic          m_last_lock;
    int            m_run;
    int            m_next;
    logic [1:0]    m_gnt;
    logic [1:0]    exp_grant = '0;
    logic          exp_busy  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push(input int port, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int gap);
        req_t r;
        r.we = we; r.lock = lock; r.addr = addr; r.wdata = wd; r.gap = gap;
        if (port == 0) qa.push_back(r); else qb.push_back(r);
    endtask

    task automatic reset_model();
        sb.delete(); qa.delete(); qb.delete();
        m_last = 1; m_last_lock = 1'b0; m_run = 0; m_next = 0; m_gnt = '0;
        m_rd[0] = '0; m_rd[1] = '0;
        exp_grant = '0; exp_busy = 1'b0;
        act_a = 1'b0; act_b = 1'b0; idle_a = 0; idle_b = 0;
        a_req = 1'b0; a_lock = 1'b0; b_req = 1'b0; b_lock = 1'b0;
    endtask

    // One access occupies three cycles; a new request is sampled once the arbiter is free.
    task automatic model_step();
        int            w;
        logic          other;
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        exp_t          e;
        if (!rst_n) begin
            exp_grant = '0; exp_busy = 1'b0;
            return;
        end
        if (cyc >= m_next && (a_req || b_req)) begin
            if (a_req && b_req) w = (m_last_lock && m_run < MB) ? m_last : 1 - m_last;
            else                w = b_req ? 1 : 0;
            other       = (w == 1) ? a_req : b_req;
            m_run       = (w == m_last && other) ? m_run + 1 : 0;
            m_last      = w;
            m_last_lock = (w == 1) ? b_lock : a_lock;
            we = (w == 1) ? b_we    : a_we;
            ad = (w == 1) ? b_addr  : a_addr;
            wd = (w == 1) ? b_wdata : a_wdata;
            if (we) m_mem[ad] = wd; else m_rd[w] = m_mem[ad];
            e.port = w; e.cyc = cyc + 1; e.rd_a = m_rd[0]; e.rd_b = m_rd[1];
            sb.push_back(e);
            if (w == 1) done_b = cyc + 1; else done_a = cyc + 1;
            m_next = cyc + 3;
            m_gnt  = (w == 1) ? 2'b10 : 2'b01;
        end
        exp_grant = (cyc + 3 == m_next || cyc + 2 == m_next) ? m_gnt : 2'b00;
        exp_busy  = (exp_grant != 2'b00);
    endtask

    task automatic drive_step();
        req_t r;
        if (act_a && done_a == cyc - 1) act_a = 1'b0;
        if (act_b && done_b == cyc - 1) act_b = 1'b0;
        if (!act_a) begin
            if (qa.size() > 0 && idle_a >= qa[0].gap) begin
                r = qa.pop_front();
                a_req = 1'b1; a_we = r.we; a_lock = r.lock; a_addr = r.addr; a_wdata = r.wdata;
                act_a = 1'b1; idle_a = 0;
            end else begin
                a_req = 1'b0; a_lock = 1'b0; idle_a++;
            end
        end
        if (!act_b) begin
            if (qb.size() > 0 && idle_b >= qb[0].gap) begin
                r = qb.pop_front();
                b_req = 1'b1; b_we = r.we; b_lock = r.lock; b_addr = r.addr; b_wdata = r.wdata;
                act_b = 1'b1; idle_b = 0;
            end else begin
                b_req = 1'b0; b_lock = 1'b0; idle_b++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        drive_step();
    endtask

    function automatic logic quiet();
        return qa.size() == 0 && qb.size() == 0 && !act_a && !act_b && sb.size() == 0;
    endfunction

    task automatic run_until_idle(input string name, input int limit);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!quiet() && n < limit);
        if (!quiet()) begin
            checks++; errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, %0d acks outstanding", name, n, sb.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reset_model();
        repeat (2) step();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: continuous grant/busy check; ack checked against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            checks++;
            if (grant !== exp_grant || busy !== exp_busy) begin
                errors++;
                $display("FAIL grant_busy: got grant=%b busy=%b, expected grant=%b busy=%b (cycle %0d)",
                         grant, busy, exp_grant, exp_busy, cyc);
            end
            if (a_ack === 1'b1 || b_ack === 1'b1) order.push_back(a_ack === 1'b1 ? 0 : 1);
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (a_ack !== (e.port == 0) || b_ack !== (e.port == 1) ||
                    a_rdata !== e.rd_a || b_rdata !== e.rd_b) begin
                    errors++;
                    $display("FAIL ack: got a_ack=%b b_ack=%b a_rdata=%h b_rdata=%h, expected port %0d a_rdata=%h b_rdata=%h (cycle %0d)",
                             a_ack, b_ack, a_rdata, b_rdata, e.port, e.rd_a, e.rd_b, cyc);
                end
            end else if (a_ack !== 1'b0 || b_ack !== 1'b0) begin
                checks++; errors++;
                $display("FAIL unexpected_ack: got a_ack=%b b_ack=%b, expected none (cycle %0d)", a_ack, b_ack, cyc);
            end
        end
    end

    initial begin
        int want_burst[12];
        want_burst = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};

        do_reset();
        @(negedge clk);
        #1;
        chk("rst_grant",   32'(grant),   32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_a_ack",   32'(a_ack),   32'd0);
        chk("rst_b_ack",   32'(b_ack),   32'd0);
        chk("rst_a_rdata", 32'(a_rdata), 32'd0);
        chk("rst_b_rdata", 32'(b_rdata), 32'd0);

        // A write then read back, plus a known value at 0x00 for later
        push(0, 1'b1, 1'b0, 8'h10, 8'h5A, 0);
        push(0, 1'b0, 1'b0, 8'h10, 8'h00, 0);
        push(0, 1'b1, 1'b0, 8'h00, 8'hC3, 0);
        run_until_idle("single_a", 50);

        // simultaneous A read / B write straight after reset
        do_reset();
        order.delete();
        push(0, 1'b0, 1'b0, 8'h00, 8'h00, 0);
        push(1, 1'b1, 1'b0, 8'h01, 8'h33, 0);
        push(1, 1'b0, 1'b0, 8'h01, 8'h00, 0);
        run_until_idle("first_tie", 50);
        chk("tie_count", 32'(order.size()), 32'd3);
        if (order.size() >= 2) begin
            chk("tie_first_a",  32'(order[0]), 32'd0);
            chk("tie_second_b", 32'(order[1]), 32'd1);
        end

        // continuous contention without lock: strict alternation
        order.delete();
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b1, 1'b0, 8'(8'h20 + i), 8'($urandom_range(0, 255)), 0);
            push(1, 1'b1, 1'b0, 8'(8'h30 + i), 8'($urandom_range(0, 255)), 0);
        end
        run_until_idle("alternate", 100);
        chk("alt_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < order.size()) chk("alt_order", 32'(order[i]), 32'(i % 2));

        // A locked burst against a waiting B: five A grants, then a forced switch
        do_reset();
        order.delete();
        for (int i = 0; i < 10; i++) push(0, 1'b1, 1'b1, 8'(8'h40 + i), 8'(i * 7), 0);
        push(1, 1'b0, 1'b0, 8'h20, 8'h00, 0);
        push(1, 1'b0, 1'b0, 8'h01, 8'h00, 0);
        run_until_idle("burst", 200);
        chk("burst_count", 32'(order.size()), 32'd12);
        for (int i = 0; i < 12; i++)
            if (i < order.size()) chk("burst_order", 32'(order[i]), 32'(want_burst[i]));

        // reset during the ACCESS cycle of a B write
        push(1, 1'b1, 1'b0, 8'h80, 8'h77, 0);
        for (int i = 0; i < 10 && sb.size() == 0; i++) step();
        chk("abort_started", 32'(sb.size()), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_grant", 32'(grant), 32'd0);
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_b_ack", 32'(b_ack), 32'd0);
        reset_model();
        repeat (2) step();
        @(negedge clk);
        #1 rst_n = 1'b1;
        order.delete();
        push(0, 1'b0, 1'b0, 8'h10, 8'h00, 0);
        push(1, 1'b0, 1'b0, 8'h01, 8'h00, 0);
        run_until_idle("after_abort", 50);
        if (order.size() > 0) chk("abort_then_a_first", 32'(order[0]), 32'd0);
        else chk("abort_then_acks", 32'(order.size()), 32'd2);

        // B read, B write 0xFF, then A reads 0xFF in the next arbitration slot
        idle_a = 0; idle_b = 0;
        push(1, 1'b0, 1'b0, 8'h01, 8'h00, 0);
        push(1, 1'b1, 1'b0, 8'hFF, 8'hA5, 0);
        push(0, 1'b0, 1'b0, 8'hFF, 8'h00, 5);
        run_until_idle("raw_ff", 60);

        // fill the whole RAM from both ports so every later read is predictable
        for (int i = 0; i < 128; i++) begin
            push(0, 1'b1, 1'b0, 8'(2 * i),     8'($urandom_range(0, 255)), 0);
            push(1, 1'b1, 1'b0, 8'(2 * i + 1), 8'($urandom_range(0, 255)), 0);
        end
        run_until_idle("fill", 2000);

        // random traffic with random locks and gaps
        for (int i = 0; i < 200; i++) begin
            push(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
            push(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end
        run_until_idle("random", 6000);
        repeat (3) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
